// File: rtl/coef_loader_if.sv
// Coefficient load stream, swap command and active-bank outputs for coef_loader.
// The master drives words and swap; the slave (coef_loader) returns status and the bank.
interface coef_loader_if #(
  parameter int M2_WIDTH = 8,
  parameter int TAPS     = 9
);
  logic [M2_WIDTH-1:0]      up_data;
  logic                     up_valid;
  logic                     up_last;
  logic                     up_ready;
  logic                     swap;
  logic                     loaded;
  logic [TAPS*M2_WIDTH-1:0] coef;
  logic                     coef_valid;
  logic                     err;

  modport master (
    output up_data, up_valid, up_last, swap,
    input  up_ready, loaded, coef, coef_valid, err
  );

  modport slave (
    input  up_data, up_valid, up_last, swap,
    output up_ready, loaded, coef, coef_valid, err
  );
endinterface

// File: rtl/coef_loader.sv
// Double-buffered kernel coefficient store: a shadow bank fills from a valid/ready stream
// while the active bank feeds the MAC taps; a swap promotes a complete shadow kernel.
module coef_tap #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         swap_i,
  output logic [W-1:0] coef_o
);
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i) shadow_d = wr_data_i;
    if (swap_i)  active_d = shadow_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign coef_o = active_q;
endmodule

module coef_loader #(
  parameter int M2_WIDTH = 8,
  parameter int TAPS     = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  coef_loader_if.slave  bus
);
  localparam int                CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TAPS - 1);

  typedef enum logic {S_LOAD, S_FULL} state_e;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 wr_cnt_q, wr_cnt_d;
  logic                             up_ready_q, loaded_q, err_q, coef_valid_q;
  logic                             err_d, coef_valid_d;
  logic                             accept, swap_take;
  logic [TAPS-1:0]                  wr_en;
  logic [TAPS-1:0][M2_WIDTH-1:0]    coef_arr;

  // up_ready_q tracks the state register, so it is never high in FULL.
  assign accept    = bus.up_valid & up_ready_q;
  assign swap_take = bus.swap & (state_q == S_FULL);

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    err_d        = 1'b0;
    coef_valid_d = coef_valid_q | swap_take;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (wr_cnt_q == LAST) begin
            state_d  = S_FULL;
            wr_cnt_d = '0;
            err_d    = ~bus.up_last;
          end else if (bus.up_last) begin
            // Short kernel: drop it and restart at tap 0.
            wr_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end
      S_FULL: begin
        if (swap_take) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_LOAD;
      wr_cnt_q     <= '0;
      up_ready_q   <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      coef_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      up_ready_q   <= (state_d == S_LOAD);
      loaded_q     <= (state_d == S_FULL);
      err_q        <= err_d;
      coef_valid_q <= coef_valid_d;
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign wr_en[i] = accept & (wr_cnt_q == CNT_W'(i));

    coef_tap #(.W(M2_WIDTH)) u_tap (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en[i]),
      .wr_data_i (bus.up_data),
      .swap_i    (swap_take),
      .coef_o    (coef_arr[i])
    );
  end

  assign bus.up_ready   = up_ready_q;
  assign bus.loaded     = loaded_q;
  assign bus.err        = err_q;
  assign bus.coef_valid = coef_valid_q;
  assign bus.coef       = coef_arr;
endmodule

// File: doc/coef_loader.md
# coef_loader

Coefficient source for the streaming-convolution MAC chain. Accepts kernel coefficients one word at a time over a valid/ready stream and collects them in a shadow bank. On a `swap` command it transfers the complete set to an active bank that drives the `m2` operands of the `multiply_add` taps. This lets a new kernel load in the background while the datapath keeps running on the current one.

## Interface
- `M2_WIDTH`, 8: coefficient width in bits (signed, two's complement); matches `multiply_add` `M2_WIDTH`.
- `TAPS`, 9: number of coefficients per kernel; must be at least 2.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `up_data`  in  M2_WIDTH: coefficient word.
- `up_valid`  in  1: `up_data` and `up_last` are valid.
- `up_last`  in  1: marks the final word of a kernel.
- `up_ready`  out  1: the block can accept a word.
- `swap`  in  1: single-cycle request to promote the shadow bank to the active bank.
- `loaded`  out  1: the shadow bank holds a complete kernel.
- `coef`  out  TAPS*M2_WIDTH: active bank; tap i occupies bits [i*M2_WIDTH +: M2_WIDTH].
- `coef_valid`  out  1: the active bank holds a kernel (set by the first swap).
- `err`  out  1: one-cycle pulse on a framing error.

## Operation
- Two states: LOAD and FULL.
  - `up_ready` is 1 only in LOAD.
  - `loaded` is 1 only in FULL.
  - Both outputs are registered.
- Write counter `wr_cnt` runs 0..TAPS-1.
  - A word is accepted when `up_valid & up_ready`.
  - An accepted word is written to `shadow[wr_cnt]`, then `wr_cnt` increments.
- Word accepted with `wr_cnt == TAPS-1`:
  - Next state is FULL and `wr_cnt` returns to 0.
  - If `up_last` is 0 on that word, `err` pulses and the kernel is still marked loaded.
- `up_last` = 1 on a word accepted with `wr_cnt < TAPS-1` (short kernel):
  - The word is written, `wr_cnt` returns to 0, the state stays LOAD, and `err` pulses.
  - The partial shadow contents are not marked loaded and are overwritten by the next kernel.
- `swap` in FULL:
  - The active bank is loaded with the shadow bank and `coef_valid` is set.
  - The state returns to LOAD.
- `swap` in LOAD is ignored, with no error. A `swap` in the same cycle as the TAPS-th accept is ignored, because the state is still LOAD.
- Shadow contents are not cleared on swap; each kernel overwrites every tap.
- The active bank changes only on an honoured swap. `coef` is stable between swaps.
- No arithmetic is performed; words are stored bit-exact.
- Reset (asynchronous, at any time, including mid-load or coincident with `swap`):
  - State goes to LOAD and `wr_cnt` to 0.
  - Shadow and active banks are cleared to 0.
  - `coef` = 0, `coef_valid` = 0, `loaded` = 0, `err` = 0, `up_ready` = 0.
- `up_ready` rises on the first rising edge after reset deassertion.

## Timing
- Accept on edge n of the TAPS-th word: at n+1, `loaded` = 1 and `up_ready` = 0.
- Accept-to-next-ready within a kernel: 0 cycles, so a full-rate stream is accepted at one word per clock.
- `swap` sampled at edge m while `loaded` = 1; at m+1:
  - `coef` is updated and `coef_valid` = 1.
  - `loaded` = 0 and `up_ready` = 1.
- The next kernel load can start at m+1. Minimum kernel period is TAPS+1 cycles.
- `err` is asserted in the cycle after the offending accept, for exactly one cycle.
- `up_data` and `up_last` are ignored whenever `up_ready` = 0 or `up_valid` = 0.

## Test plan
- **Reset values:** hold `rst` = 0 for 6 cycles with random inputs, then release.
  - During reset: all outputs 0.
  - `up_ready` = 1 one cycle after release.
- **Full-rate load and swap (TAPS=9):** stream 1..9 with `up_last` on 9.
  - `loaded` = 1 the cycle after word 9.
  - After a `swap` pulse, `coef` taps 0..8 = 1..9, `coef_valid` = 1, `up_ready` = 1.
- **Background load, signed values:** while the active kernel is 1..9, load -1,-2,...,-9 with `up_valid` toggling every other cycle.
  - `coef` stays 1..9 until `swap`.
  - Then taps read 0xFF, 0xFE, ..., 0xF7 (two's complement).
- **Short kernel:** send 4 words with `up_last` on the 4th.
  - `err` pulses once, `loaded` stays 0.
  - A following proper 9-word kernel loads and swaps correctly, with no residue from the short one.
- **Missing last and ignored swaps:** send 9 words with `up_last` = 0.
  - `err` pulses once and `loaded` = 1.
  - A `swap` issued mid-load, or in the same cycle as word 9, leaves `coef` unchanged.
- **Reset mid-operation:** assert `rst` after 5 accepted words, and separately in the cycle of a `swap`.
  - All banks read 0 and `coef_valid` = 0.
  - The next full load starts at tap 0.
